// File: rtl/rs_pkg.sv
// Shared constants, state type and GF(2^8) helper for the RS(18,16) encoder.
// Field polynomial x^8+x^4+x^3+x^2+1 (0x11D), generator (x+a)(x+a^2), a=0x02.
package rs_pkg;

    localparam int SYMBOL_WIDTH = 8;
    localparam int K            = 16;
    localparam int N            = K + 2;

    localparam logic [7:0] GF_POLY = 8'h1D;
    localparam logic [7:0] G1      = 8'h06;
    localparam logic [7:0] G0      = 8'h08;

    typedef enum logic [1:0] {
        DATA = 2'd0,
        PAR1 = 2'd1,
        PAR0 = 2'd2
    } rs_state_t;

    // Multiply by a=x modulo the field polynomial.
    function automatic logic [7:0] gf_xtime(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? GF_POLY : 8'h00);
    endfunction

endpackage

// File: rtl/gf256_mul_const.sv
// Constant GF(2^8) multiplier: y = a * CONST mod 0x11D, folded to a pure XOR network.
import rs_pkg::*;

module gf256_mul_const #(
    parameter logic [7:0] CONST = 8'h01
) (
    input  logic [7:0] a,
    output logic [7:0] y
);

    // CONST is elaboration-time, so the loop collapses to XORs of shifted copies of a.
    always_comb begin
        logic [7:0] t;
        y = 8'h00;
        t = a;
        for (int i = 0; i < 8; i++) begin
            if (CONST[i]) y = y ^ t;
            t = gf_xtime(t);
        end
    end

endmodule

// File: rtl/rs_encoder_18_16.sv
// Symbol-serial systematic RS(18,16) encoder: 16 data symbols passed through, 2 parity appended.
// Optional RS_ENC_CW_OUT_EN adds a parallel 144-bit codeword capture with a 1-cycle cw_valid pulse.
//
// state | meaning
// DATA  | forwarding data symbols, LFSR absorbing each accepted symbol
// PAR1  | loading parity p1 (r1) into the output register
// PAR0  | loading parity p0 (r0), clearing the LFSR, returning to DATA

module rs_encoder_18_16 #(
    parameter int SYMBOL_WIDTH = 8,
    parameter int K            = 16
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        in_valid,
    output logic                        in_ready,
    input  logic [SYMBOL_WIDTH-1:0]     in_sym,
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic [SYMBOL_WIDTH-1:0]     out_sym,
    output logic                        out_sop,
    output logic                        out_eop
`ifdef RS_ENC_CW_OUT_EN
    ,
    output logic                        cw_valid,
    output logic [SYMBOL_WIDTH*(K+2)-1:0] cw
`endif
);

    import rs_pkg::*;

    localparam int NSYM  = K + 2;
    localparam int CNT_W = $clog2(K);

    rs_state_t               state;
    logic [CNT_W-1:0]        cnt;
    logic [SYMBOL_WIDTH-1:0] r1;
    logic [SYMBOL_WIDTH-1:0] r0;
    logic [SYMBOL_WIDTH-1:0] fb;
    logic [SYMBOL_WIDTH-1:0] fb_g1;
    logic [SYMBOL_WIDTH-1:0] fb_g0;
    logic                    slot_free;
    logic                    accept;

    assign slot_free = !out_valid || out_ready;
    assign in_ready  = (state == DATA) && slot_free;
    assign accept    = in_valid && in_ready;
    assign fb        = in_sym ^ r1;

    gf256_mul_const #(.CONST(G1)) u_mul_g1 (.a(fb), .y(fb_g1));
    gf256_mul_const #(.CONST(G0)) u_mul_g0 (.a(fb), .y(fb_g0));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= DATA;
            cnt       <= '0;
            r1        <= '0;
            r0        <= '0;
            out_valid <= 1'b0;
            out_sym   <= '0;
            out_sop   <= 1'b0;
            out_eop   <= 1'b0;
        end else begin
            case (state)
                DATA: begin
                    if (accept) begin
                        out_valid <= 1'b1;
                        out_sym   <= in_sym;
                        out_sop   <= (cnt == '0);
                        out_eop   <= 1'b0;
                        r1        <= r0 ^ fb_g1;
                        r0        <= fb_g0;
                        if (cnt == CNT_W'(K - 1)) begin
                            cnt   <= '0;
                            state <= PAR1;
                        end else begin
                            cnt <= cnt + 1'b1;
                        end
                    end else if (slot_free) begin
                        out_valid <= 1'b0;
                    end
                end
                PAR1: begin
                    if (slot_free) begin
                        out_valid <= 1'b1;
                        out_sym   <= r1;
                        out_sop   <= 1'b0;
                        out_eop   <= 1'b0;
                        state     <= PAR0;
                    end
                end
                PAR0: begin
                    if (slot_free) begin
                        out_valid <= 1'b1;
                        out_sym   <= r0;
                        out_sop   <= 1'b0;
                        out_eop   <= 1'b1;
                        r1        <= '0;
                        r0        <= '0;
                        state     <= DATA;
                    end
                end
                default: state <= DATA;
            endcase
        end
    end

`ifdef RS_ENC_CW_OUT_EN
    // Only the first 17 symbols need storing; p0 is taken straight from out_sym at capture.
    logic [SYMBOL_WIDTH*(NSYM-1)-1:0] cw_sr;
    logic                             out_fire;

    assign out_fire = out_valid && out_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cw_sr    <= '0;
            cw       <= '0;
            cw_valid <= 1'b0;
        end else begin
            cw_valid <= out_fire && out_eop;
            if (out_fire) begin
                cw_sr <= {cw_sr[SYMBOL_WIDTH*(NSYM-2)-1:0], out_sym};
                if (out_eop) cw <= {cw_sr, out_sym};
            end
        end
    end
`endif

endmodule

// File: tb/tb_rs_encoder_18_16.sv
// Scoreboard bench for rs_encoder_18_16; parity reference solved from v(a)=v(a^2)=0.
// Build with RS_ENC_CW_OUT_EN defined to also cover the parallel codeword output.
`timescale 1ns/1ps

module tb_rs_encoder_18_16;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [7:0]  in_sym;
    logic        out_valid;
    logic        out_ready;
    logic [7:0]  out_sym;
    logic        out_sop;
    logic        out_eop;
`ifdef RS_ENC_CW_OUT_EN
    logic          cw_valid;
    logic [143:0]  cw;
`endif

    rs_encoder_18_16 dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready), .in_sym(in_sym),
        .out_valid(out_valid), .out_ready(out_ready), .out_sym(out_sym),
        .out_sop(out_sop), .out_eop(out_eop)
`ifdef RS_ENC_CW_OUT_EN
        , .cw_valid(cw_valid), .cw(cw)
`endif
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [7:0] sym;
        logic       sop;
        logic       eop;
    } exp_t;

    exp_t        exp_q[$];
    logic [7:0]  data_q[$];
    logic [7:0]  cwbuf[16];
    int          bcnt;
    int          total = 0;
    int          bad   = 0;
    int          cyc   = 0;
    int          xfers = 0;
    int          first_xfer_cyc;
    int          last_xfer_cyc;
    bit          rdy_rand;
    bit          gap_en;
    bit          hold_prev;
    logic [7:0]  held_sym;
    logic        held_sop;
    logic        held_eop;
    logic [7:0]  p_prev;
    logic [7:0]  p_last;
    bit          expect_cw;
    int          cw_pulses;
    logic [143:0] exp_cw_acc;
    logic [143:0] exp_cw_done;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] gm(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] r, x, y;
        r = 8'h00; x = a; y = b;
        for (int i = 0; i < 8; i++) begin
            if (y[0]) r = r ^ x;
            x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1D : 8'h00);
            y = y >> 1;
        end
        return r;
    endfunction

    function automatic logic [7:0] gp(input logic [7:0] b, input int e);
        logic [7:0] r;
        r = 8'h01;
        for (int i = 0; i < e; i++) r = gm(r, b);
        return r;
    endfunction

    function automatic logic [7:0] ginv(input logic [7:0] b);
        for (int x = 1; x < 256; x++)
            if (gm(b, 8'(x)) == 8'h01) return 8'(x);
        return 8'h00;
    endfunction

    // Parity from the two syndrome equations: p1*a + p0 = S1, p1*a^2 + p0 = S2.
    function automatic logic [15:0] ref_parity();
        logic [7:0] s1, s2, p1, p0;
        s1 = 8'h00; s2 = 8'h00;
        for (int i = 0; i < 16; i++) begin
            s1 = s1 ^ gm(cwbuf[i], gp(8'h02, 17 - i));
            s2 = s2 ^ gm(cwbuf[i], gp(8'h04, 17 - i));
        end
        p1 = gm(s1 ^ s2, ginv(8'h06));
        p0 = s1 ^ gm(p1, 8'h02);
        return {p1, p0};
    endfunction

    function automatic logic [7:0] cw_syndrome(input logic [143:0] v, input logic [7:0] root);
        logic [7:0] s;
        s = 8'h00;
        for (int i = 0; i < 18; i++) s = s ^ gm(v[143 - 8*i -: 8], gp(root, 17 - i));
        return s;
    endfunction

    task automatic cycle();
        bit         in_par;
        logic       exp_ir;
        exp_t       e;
        logic [15:0] par;
        @(negedge clk);
        out_ready = rdy_rand ? ($urandom_range(0, 1) == 1) : 1'b1;
        if (data_q.size() > 0 && !(gap_en && $urandom_range(0, 3) == 0)) begin
            in_valid = 1'b1;
            in_sym   = data_q[0];
        end else begin
            in_valid = 1'b0;
            in_sym   = 8'($urandom);
        end
        #1;
`ifdef RS_ENC_CW_OUT_EN
        chk("cw_valid", 32'(cw_valid), 32'(expect_cw));
        if (cw_valid) begin
            cw_pulses++;
            chk("cw_value_lo", cw[31:0], exp_cw_done[31:0]);
            chk("cw_value_hi", cw[143:112], exp_cw_done[143:112]);
            chk("cw_s1", 32'(cw_syndrome(cw, 8'h02)), 32'h0);
            chk("cw_s2", 32'(cw_syndrome(cw, 8'h04)), 32'h0);
        end
`endif
        expect_cw = 1'b0;
        if (hold_prev) begin
            chk("stall_valid", 32'(out_valid), 32'h1);
            chk("stall_sym",   32'(out_sym),   32'(held_sym));
            chk("stall_flags", {30'h0, out_sop, out_eop}, {30'h0, held_sop, held_eop});
        end
        in_par = (exp_q.size() > 0) && exp_q[$].eop && (exp_q.size() > (out_valid ? 1 : 0));
        exp_ir = in_par ? 1'b0 : (!out_valid || out_ready);
        chk("in_ready", 32'(in_ready), 32'(exp_ir));
        if (out_valid && out_ready) begin
            chk("unexpected_out", 32'(exp_q.size() != 0), 32'h1);
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                chk("out_sym", 32'(out_sym), 32'(e.sym));
                chk("out_sop_eop", {30'h0, out_sop, out_eop}, {30'h0, e.sop, e.eop});
                exp_cw_acc = {exp_cw_acc[135:0], e.sym};
                if (e.eop) begin
                    exp_cw_done = exp_cw_acc;
                    expect_cw   = 1'b1;
                end
            end
            p_prev = p_last;
            p_last = out_sym;
            if (xfers == 0) first_xfer_cyc = cyc;
            last_xfer_cyc = cyc;
            xfers++;
        end
        hold_prev = out_valid && !out_ready;
        held_sym  = out_sym;
        held_sop  = out_sop;
        held_eop  = out_eop;
        if (in_valid && in_ready) begin
            void'(data_q.pop_front());
            cwbuf[bcnt] = in_sym;
            exp_q.push_back('{sym: in_sym, sop: (bcnt == 0), eop: 1'b0});
            bcnt++;
            if (bcnt == 16) begin
                par = ref_parity();
                exp_q.push_back('{sym: par[15:8], sop: 1'b0, eop: 1'b0});
                exp_q.push_back('{sym: par[7:0],  sop: 1'b0, eop: 1'b1});
                bcnt = 0;
            end
        end
        cyc++;
    endtask

    task automatic drain(input int maxc);
        int n;
        n = 0;
        while ((data_q.size() > 0 || exp_q.size() > 0) && n < maxc) begin
            cycle();
            n++;
        end
        chk("drain_in_budget", 32'(n < maxc), 32'h1);
        repeat (2) cycle();
    endtask

    task automatic do_reset();
        @(negedge clk);
        #2 rst_n = 1'b0;
        in_valid = 1'b0;
        repeat (2) begin
            @(negedge clk);
            #1;
            chk("rst_out_valid", 32'(out_valid), 32'h0);
            chk("rst_out_sym",   32'(out_sym),   32'h0);
            chk("rst_out_flags", {30'h0, out_sop, out_eop}, 32'h0);
`ifdef RS_ENC_CW_OUT_EN
            chk("rst_cw_valid", 32'(cw_valid), 32'h0);
            chk("rst_cw", cw[31:0] | cw[143:112], 32'h0);
`endif
        end
        exp_q.delete();
        data_q.delete();
        bcnt      = 0;
        hold_prev = 1'b0;
        expect_cw = 1'b0;
        rst_n     = 1'b1;
    endtask

    task automatic push_case2(input logic [7:0] last);
        for (int i = 0; i < 15; i++) data_q.push_back(8'h00);
        data_q.push_back(last);
    endtask

    initial begin
        rst_n = 1'b0; in_valid = 1'b0; in_sym = 8'h00; out_ready = 1'b0;
        rdy_rand = 1'b0; gap_en = 1'b0; hold_prev = 1'b0; bcnt = 0;
        expect_cw = 1'b0; cw_pulses = 0; exp_cw_acc = '0; exp_cw_done = '0;
        p_prev = 8'h00; p_last = 8'h00; first_xfer_cyc = 0; last_xfer_cyc = 0;
        #23;
        chk("reset_out_valid", 32'(out_valid), 32'h0);
        chk("reset_out_sym",   32'(out_sym),   32'h0);
        chk("reset_flags",     {30'h0, out_sop, out_eop}, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;

        // 1: all-zero codeword
        for (int i = 0; i < 16; i++) data_q.push_back(8'h00);
        drain(200);
        chk("zero_p1", 32'(p_prev), 32'h00);
        chk("zero_p0", 32'(p_last), 32'h00);

        // 2: single unit coefficient at x^2, then 0x02 at x^2
        p_last = 8'hFF;
        push_case2(8'h01);
        drain(200);
        chk("case2a_p1", 32'(p_prev), 32'h06);
        chk("case2a_p0", 32'(p_last), 32'h08);
        push_case2(8'h02);
        drain(200);
        chk("case2b_p1", 32'(p_prev), 32'h0C);
        chk("case2b_p0", 32'(p_last), 32'h10);

        // 3: random data with random backpressure and input gaps
        rdy_rand = 1'b1; gap_en = 1'b1;
        for (int i = 0; i < 48; i++) data_q.push_back(8'($urandom));
        drain(2000);
        rdy_rand = 1'b0; gap_en = 1'b0;

        // 4: back-to-back codewords with continuous input
        xfers = 0;
        for (int i = 0; i < 32; i++) data_q.push_back(8'($urandom));
        drain(200);
        chk("b2b_xfers", 32'(xfers), 32'd36);
        chk("b2b_span",  32'(last_xfer_cyc - first_xfer_cyc + 1), 32'd36);

        // 5: reset mid-codeword, then a fresh case-2 stream
        for (int i = 0; i < 7; i++) data_q.push_back(8'($urandom_range(1, 255)));
        while (data_q.size() > 0) cycle();
        do_reset();
        p_last = 8'hFF;
        push_case2(8'h01);
        drain(200);
        chk("post_rst_p1", 32'(p_prev), 32'h06);
        chk("post_rst_p0", 32'(p_last), 32'h08);

`ifdef RS_ENC_CW_OUT_EN
        // 6: random codeword through the parallel capture
        cw_pulses = 0;
        rdy_rand = 1'b1;
        for (int i = 0; i < 16; i++) data_q.push_back(8'($urandom));
        drain(1000);
        rdy_rand = 1'b0;
        chk("cw_pulse_count", 32'(cw_pulses), 32'd1);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
